// File: rtl/hazard_scoreboard_pkg.sv
// Shared constants for the hazard scoreboard.
// Forward-select encodings and default sizing.
package hazard_scoreboard_pkg;

  localparam int NREG_D       = 8;
  localparam int RA_W_D       = 3;
  localparam int PIPE_DEPTH_D = 3;
  localparam int LAT_W_D      = 2;
  localparam int FS_W_D       = 2;

  typedef enum logic [1:0] {
    FS_RF  = 2'd0,
    FS_EX  = 2'd1,
    FS_MEM = 2'd2,
    FS_WB  = 2'd3
  } fwd_sel_e;

endpackage

// File: rtl/sb_entry.sv
// One scoreboard entry: pending flag, ready and writeback countdowns.
// Frozen by mem_busy; a new writer overrides any in-flight state.
module sb_entry
  import hazard_scoreboard_pkg::*;
#(
  parameter int PIPE_DEPTH = PIPE_DEPTH_D,
  parameter int LAT_W      = LAT_W_D,
  parameter int FS_W       = FS_W_D
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             freeze_i,
  input  logic             load_i,
  input  logic [LAT_W-1:0] lat_i,
  input  logic             squash_i,
  output logic             pend_o,
  output logic [LAT_W-1:0] rdy_o,
  output logic [FS_W-1:0]  wb_o
);

  logic             pend_q, pend_d;
  logic [LAT_W-1:0] rdy_q, rdy_d;
  logic [FS_W-1:0]  wb_q, wb_d;

  // Squash only hits the writer issued last cycle (wb untouched since).
  logic squash_hit;
  assign squash_hit = squash_i & pend_q &
                      (wb_q == FS_W'(PIPE_DEPTH));

  // Next-state: load beats squash beats normal countdown.
  always_comb begin
    pend_d = pend_q;
    rdy_d  = rdy_q;
    wb_d   = wb_q;
    if (!freeze_i) begin
      if (load_i) begin
        pend_d = 1'b1;
        rdy_d  = lat_i;
        wb_d   = FS_W'(PIPE_DEPTH);
      end else if (squash_hit) begin
        pend_d = 1'b0;
        rdy_d  = '0;
        wb_d   = '0;
      end else if (pend_q) begin
        if (rdy_q != '0) rdy_d = rdy_q - LAT_W'(1);
        wb_d = wb_q - FS_W'(1);
        if (wb_q == FS_W'(1)) pend_d = 1'b0;
      end
    end
  end

  // Entry state registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pend_q <= 1'b0;
      rdy_q  <= '0;
      wb_q   <= '0;
    end else begin
      pend_q <= pend_d;
      rdy_q  <= rdy_d;
      wb_q   <= wb_d;
    end
  end

  assign pend_o = pend_q;
  assign rdy_o  = rdy_q;
  assign wb_o   = wb_q;

endmodule

// File: rtl/hazard_scoreboard.sv
// Register-hazard scoreboard: stall, forward select, stall counter.
// One sb_entry per architectural register.
module hazard_scoreboard
  import hazard_scoreboard_pkg::*;
#(
  parameter int NREG       = NREG_D,
  parameter int RA_W       = RA_W_D,
  parameter int PIPE_DEPTH = PIPE_DEPTH_D,
  parameter int LAT_W      = LAT_W_D,
  parameter int FS_W       = FS_W_D
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             issue_valid,
  input  logic [RA_W-1:0]  issue_rs,
  input  logic [RA_W-1:0]  issue_rt,
  input  logic             issue_rs_used,
  input  logic             issue_rt_used,
  input  logic             issue_wr,
  input  logic [RA_W-1:0]  issue_wr_reg,
  input  logic [LAT_W-1:0] issue_lat,
  input  logic             issue_is_branch,
  input  logic             mem_busy,
  input  logic             flush,
  output logic             stall,
  output logic             issue_accept,
  output logic [FS_W-1:0]  fwd_sel_rs,
  output logic [FS_W-1:0]  fwd_sel_rt,
  output logic [15:0]      stall_cnt
);

  localparam logic [FS_W-1:0] STG_BASE = FS_W'(PIPE_DEPTH + 1);

  logic             pend [NREG];
  logic [LAT_W-1:0] rdy  [NREG];
  logic [FS_W-1:0]  wb   [NREG];

  logic            lv_q, lv_d;
  logic [RA_W-1:0] lreg_q, lreg_d;
  logic [15:0]     cnt_q, cnt_d;

  for (genvar g = 0; g < NREG; g++) begin : g_ent
    sb_entry #(
      .PIPE_DEPTH(PIPE_DEPTH),
      .LAT_W     (LAT_W),
      .FS_W      (FS_W)
    ) u_ent (
      .clk     (clk),
      .rst_n   (rst_n),
      .freeze_i(mem_busy),
      .load_i  (issue_accept & issue_wr &
                (issue_wr_reg == RA_W'(g))),
      .lat_i   (issue_lat),
      .squash_i(flush & lv_q & (lreg_q == RA_W'(g))),
      .pend_o  (pend[g]),
      .rdy_o   (rdy[g]),
      .wb_o    (wb[g])
    );
  end

  logic [FS_W-1:0] stg_rs, stg_rt;
  logic            haz_rs, haz_rt, bhaz_rs;

  // Hazard detection and forward-select generation.
  always_comb begin
    stg_rs  = pend[issue_rs] ? STG_BASE - wb[issue_rs] : '0;
    stg_rt  = pend[issue_rt] ? STG_BASE - wb[issue_rt] : '0;
    haz_rs  = pend[issue_rs] & (rdy[issue_rs] != '0);
    haz_rt  = pend[issue_rt] & (rdy[issue_rt] != '0);
    bhaz_rs = haz_rs |
              (pend[issue_rs] & (stg_rs == FS_W'(FS_EX)));
    stall = issue_valid &
            ((issue_rs_used &
              (issue_is_branch ? bhaz_rs : haz_rs)) |
             (issue_rt_used & haz_rt));
    issue_accept = issue_valid & ~stall & ~mem_busy & ~flush;
    fwd_sel_rs = FS_W'(FS_RF);
    fwd_sel_rt = FS_W'(FS_RF);
    if (issue_rs_used & pend[issue_rs] & ~stall) fwd_sel_rs = stg_rs;
    if (issue_rt_used & pend[issue_rt] & ~stall) fwd_sel_rt = stg_rt;
  end

  // Next-state for last-issue tracker and saturating stall counter.
  always_comb begin
    lv_d   = lv_q;
    lreg_d = lreg_q;
    cnt_d  = cnt_q;
    if (!mem_busy) begin
      lv_d   = issue_accept & issue_wr;
      lreg_d = issue_wr_reg;
    end
    if (stall && cnt_q != 16'hFFFF) cnt_d = cnt_q + 16'd1;
  end

  // Last-issue and stall counter registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      lv_q   <= 1'b0;
      lreg_q <= '0;
      cnt_q  <= '0;
    end else begin
      lv_q   <= lv_d;
      lreg_q <= lreg_d;
      cnt_q  <= cnt_d;
    end
  end

  assign stall_cnt = cnt_q;

endmodule

// File: tb/tb_hazard_scoreboard.sv
// Scoreboard bench for hazard_scoreboard.
// Directed vectors queue expectations; a negedge monitor checks them.
module tb_hazard_scoreboard;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        issue_valid = 1'b0;
  logic [2:0]  issue_rs = '0;
  logic [2:0]  issue_rt = '0;
  logic        issue_rs_used = 1'b0;
  logic        issue_rt_used = 1'b0;
  logic        issue_wr = 1'b0;
  logic [2:0]  issue_wr_reg = '0;
  logic [1:0]  issue_lat = '0;
  logic        issue_is_branch = 1'b0;
  logic        mem_busy = 1'b0;
  logic        flush = 1'b0;
  logic        stall;
  logic        issue_accept;
  logic [1:0]  fwd_sel_rs;
  logic [1:0]  fwd_sel_rt;
  logic [15:0] stall_cnt;

  hazard_scoreboard dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .issue_valid    (issue_valid),
    .issue_rs       (issue_rs),
    .issue_rt       (issue_rt),
    .issue_rs_used  (issue_rs_used),
    .issue_rt_used  (issue_rt_used),
    .issue_wr       (issue_wr),
    .issue_wr_reg   (issue_wr_reg),
    .issue_lat      (issue_lat),
    .issue_is_branch(issue_is_branch),
    .mem_busy       (mem_busy),
    .flush          (flush),
    .stall          (stall),
    .issue_accept   (issue_accept),
    .fwd_sel_rs     (fwd_sel_rs),
    .fwd_sel_rt     (fwd_sel_rt),
    .stall_cnt      (stall_cnt)
  );

  always #5 clk = ~clk;

  typedef struct {
    string       nm;
    logic        st;
    logic        acc;
    logic [1:0]  frs;
    logic [1:0]  frt;
    logic [15:0] cnt;
  } exp_t;

  exp_t q[$];
  int   checks = 0;
  int   errors = 0;

  // staged stimulus, applied by go()
  logic       s_rst, s_v, s_rsu, s_rtu, s_wr, s_br, s_mb, s_fl;
  logic [2:0] s_rs, s_rt, s_wd;
  logic [1:0] s_lat;

  task automatic clr();
    s_rst = 1'b1; s_v = 0; s_rsu = 0; s_rtu = 0; s_wr = 0;
    s_br = 0; s_mb = 0; s_fl = 0;
    s_rs = 0; s_rt = 0; s_wd = 0; s_lat = 0;
  endtask

  task automatic go(input string nm, input logic st,
                    input logic acc, input logic [1:0] frs,
                    input logic [1:0] frt, input logic [15:0] cnt);
    exp_t e;
    @(posedge clk);
    #1;
    rst_n = s_rst;
    issue_valid = s_v;
    issue_rs = s_rs;
    issue_rt = s_rt;
    issue_rs_used = s_rsu;
    issue_rt_used = s_rtu;
    issue_wr = s_wr;
    issue_wr_reg = s_wd;
    issue_lat = s_lat;
    issue_is_branch = s_br;
    mem_busy = s_mb;
    flush = s_fl;
    e.nm = nm; e.st = st; e.acc = acc;
    e.frs = frs; e.frt = frt; e.cnt = cnt;
    q.push_back(e);
  endtask

  task automatic idle(input int n, input logic [15:0] cnt);
    for (int i = 0; i < n; i++) begin
      clr();
      go("idle", 0, 0, 0, 0, cnt);
    end
  endtask

  // Monitor: compare DUT outputs with the oldest pending expectation.
  always @(negedge clk) begin
    if (q.size() > 0) begin
      exp_t e;
      e = q.pop_front();
      checks++;
      if ({stall, issue_accept, fwd_sel_rs, fwd_sel_rt, stall_cnt} !==
          {e.st, e.acc, e.frs, e.frt, e.cnt}) begin
        errors++;
        $display("FAIL %s: got stall=%b acc=%b frs=%0d frt=%0d cnt=%0d want stall=%b acc=%b frs=%0d frt=%0d cnt=%0d",
                 e.nm, stall, issue_accept, fwd_sel_rs, fwd_sel_rt,
                 stall_cnt, e.st, e.acc, e.frs, e.frt, e.cnt);
      end
    end
  end

  initial begin
    int c;
    // reset state: nothing pending, counter clear
    clr(); s_rst = 0; s_v = 1; s_rs = 3; s_rsu = 1; s_rt = 2; s_rtu = 1;
    go("reset", 0, 1, 0, 0, 0);

    // ALU R3 then consumer: forward from EX
    clr(); s_v = 1; s_wr = 1; s_wd = 3; s_lat = 0;
    go("alu_wr_r3", 0, 1, 0, 0, 0);
    clr(); s_v = 1; s_rs = 3; s_rsu = 1; s_rt = 1; s_rtu = 1;
    go("alu_use_ex", 0, 1, 1, 0, 0);
    idle(3, 0);

    // load R2 then consumer on rt: one stall, then MEM forward
    clr(); s_v = 1; s_wr = 1; s_wd = 2; s_lat = 1;
    go("ld_wr_r2", 0, 1, 0, 0, 0);
    clr(); s_v = 1; s_rt = 2; s_rtu = 1;
    go("ld_use_stall", 1, 0, 0, 0, 0);
    go("ld_use_fwd", 0, 1, 0, 2, 1);
    idle(3, 1);

    // ALU R5 then branch on R5: decode-use stall
    clr(); s_v = 1; s_wr = 1; s_wd = 5;
    go("alu_wr_r5", 0, 1, 0, 0, 1);
    clr(); s_v = 1; s_br = 1; s_rs = 5; s_rsu = 1;
    go("br_stall", 1, 0, 0, 0, 1);
    go("br_fwd_mem", 0, 1, 2, 0, 2);
    idle(3, 2);

    // load R2 with mem_busy freeze for 4 cycles
    clr(); s_v = 1; s_wr = 1; s_wd = 2; s_lat = 1;
    go("ld2_wr_r2", 0, 1, 0, 0, 2);
    clr(); s_v = 1; s_rs = 2; s_rsu = 1; s_mb = 1;
    go("busy0", 1, 0, 0, 0, 2);
    go("busy1", 1, 0, 0, 0, 3);
    go("busy2", 1, 0, 0, 0, 4);
    go("busy3", 1, 0, 0, 0, 5);
    s_mb = 0;
    go("busy_rel_stall", 1, 0, 0, 0, 6);
    go("busy_rel_fwd", 0, 1, 2, 0, 7);
    idle(3, 7);

    // write R4, flush next cycle with a valid issue
    clr(); s_v = 1; s_wr = 1; s_wd = 4;
    go("wr_r4", 0, 1, 0, 0, 7);
    clr(); s_v = 1; s_fl = 1; s_wr = 1; s_wd = 6; s_rs = 1; s_rsu = 1;
    go("flush_drop", 0, 0, 0, 0, 7);
    clr(); s_v = 1; s_rs = 4; s_rsu = 1; s_rt = 6; s_rtu = 1;
    go("after_flush", 0, 1, 0, 0, 7);

    // flush with no last writer leaves R1 intact; WB forward
    clr(); s_v = 1; s_wr = 1; s_wd = 1;
    go("wr_r1", 0, 1, 0, 0, 7);
    clr(); s_v = 1;
    go("nop", 0, 1, 0, 0, 7);
    clr(); s_fl = 1;
    go("flush_nolv", 0, 0, 0, 0, 7);
    clr(); s_v = 1; s_rs = 1; s_rsu = 1;
    go("fwd_wb", 0, 1, 3, 0, 7);
    idle(2, 7);

    // long frozen stall: counter saturates
    clr(); s_v = 1; s_wr = 1; s_wd = 7; s_lat = 1;
    go("ld_wr_r7", 0, 1, 0, 0, 7);
    clr(); s_v = 1; s_rs = 7; s_rsu = 1; s_mb = 1;
    for (int i = 0; i < 70000; i++) begin
      c = 7 + i;
      if (c > 65535) c = 65535;
      go("sat_stall", 1, 0, 0, 0, 16'(c));
    end

    // async reset mid-operation while frozen
    s_rst = 0;
    go("rst_busy", 0, 0, 0, 0, 0);
    s_mb = 0; s_rt = 7; s_rtu = 1;
    go("rst_hold", 0, 1, 0, 0, 0);
    s_rst = 1;
    go("post_rst", 0, 1, 0, 0, 0);

    @(negedge clk);
    #1;
    checks++;
    if (q.size() != 0) begin
      errors++;
      $display("FAIL drain: got %0d pending want 0", q.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
